// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns 1-cycle event strobes into active-low pulses of
// LOW_CYC clocks, each followed by at least GAP_CYC clocks high.
// Strobes that arrive while a pulse or gap is running are queued in a
// saturating pending counter (up to QDEPTH). A strobe that cannot be kept
// raises ovf for one cycle.
//
// Optional feature macro: PULSE_QUEUE_EN
//   defined   : strobes arriving while busy are queued.
//   undefined : pending stays 0. A strobe arriving while busy is dropped
//               with ovf. The one exception is a strobe on the gap-exit edge,
//               which starts a new pulse immediately.
//
// Strobe acceptance: trig needs no handshake. It is sampled on every rising
// edge and either starts a pulse, is queued, or is dropped with ovf=1 on the
// following cycle. No strobe is ever lost silently.
//
// The FSM state is held in the 'state' signal. It is visible to checkers
// through the hierarchy.

module pulse_stretcher #(
  parameter int LOW_CYC = 8000,
  parameter int GAP_CYC = 8000,
  parameter int QDEPTH  = 7,
  parameter int CW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  output logic       out,
  output logic       busy,
  output logic [3:0] pending,
  output logic       ovf
);

  // FSM encoding. The unused code 2'b11 recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOW  = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  // Last counter value of each phase. The phase ends on the edge that sees
  // this value.
  localparam logic [CW-1:0] LOW_LAST = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Queue capacity. It is forced to zero when queueing is compiled out.
  // With a capacity of zero, every strobe that arrives while busy is
  // dropped. A gap then always ends in IDLE unless a strobe lands on the
  // exit edge itself.
`ifdef PULSE_QUEUE_EN
  localparam logic QUEUE_ON = 1'b1;
`else
  localparam logic QUEUE_ON = 1'b0;
`endif
  localparam logic [3:0] QMAX = 4'(QDEPTH) & {4{QUEUE_ON}};

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [3:0]    pend_n;
  logic          out_n;
  logic          ovf_n;
  logic          low_done;
  logic          gap_done;
  logic          room;

  assign low_done = (cnt == LOW_LAST);
  assign gap_done = (cnt == GAP_LAST);
  assign room     = (pending < QMAX);

  // Next-state, counter, queue and output decode for one clock edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_ONE;
    pend_n  = pending;
    out_n   = out;
    ovf_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n  = '0;
        pend_n = 4'd0;
        out_n  = 1'b1;
        if (trig) begin
          state_n = ST_LOW;
          out_n   = 1'b0;
        end
      end
      ST_LOW: begin
        if (low_done) begin
          state_n = ST_GAP;
          cnt_n   = '0;
          out_n   = 1'b1;
        end
        // A strobe during the pulse is queued if there is room.
        // Otherwise it is reported as dropped.
        if (trig) begin
          if (room) pend_n = pending + 4'd1;
          else      ovf_n  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          cnt_n = '0;
          if (trig) begin
            // A strobe on the exit edge starts the next pulse directly.
            // If an entry would otherwise have been consumed, the +1 and -1
            // cancel, so pending is left unchanged.
            state_n = ST_LOW;
            out_n   = 1'b0;
          end else if (pending != 4'd0) begin
            state_n = ST_LOW;
            out_n   = 1'b0;
            pend_n  = pending - 4'd1;
          end else begin
            state_n = ST_IDLE;
            out_n   = 1'b1;
          end
        end else if (trig) begin
          if (room) pend_n = pending + 4'd1;
          else      ovf_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        pend_n  = 4'd0;
        out_n   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  // A reset in the middle of a pulse returns out high on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= 4'd0;
      out     <= 1'b1;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pend_n;
      out     <= out_n;
      busy    <= (state_n != ST_IDLE);
      ovf     <= ovf_n;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher (LOW_CYC=4, GAP_CYC=3, QDEPTH=2).
// The reference model tracks the clocks left in the current pulse and gap,
// plus a count of queued strobes. Every output is compared on every cycle.
// Directed patterns come first, followed by random strobes and resets.
module tb_pulse_stretcher;
  localparam int LOW_CYC = 4;
  localparam int GAP_CYC = 3;
  localparam int QDEPTH  = 2;
  localparam int CW      = 20;
`ifdef PULSE_QUEUE_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig = 1'b0;
  logic       out;
  logic       busy;
  logic [3:0] pending;
  logic       ovf;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // Reference state: clocks of low/high still owed, queued strobes, drop flag.
  int m_low  = 0;
  int m_gap  = 0;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  pulse_stretcher #(
    .LOW_CYC(LOW_CYC), .GAP_CYC(GAP_CYC), .QDEPTH(QDEPTH), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig),
    .out(out), .busy(busy), .pending(pending), .ovf(ovf)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic enqueue();
    if (Q_EN && m_pend < QDEPTH) m_pend++;
    else m_ovf = 1'b1;
  endtask

  // Advance the reference model by one rising edge.
  task automatic model_edge(input bit r, input bit t);
    if (!r) begin
      m_low = 0; m_gap = 0; m_pend = 0; m_ovf = 1'b0;
      return;
    end
    m_ovf = 1'b0;
    if (m_low == 0 && m_gap == 0) begin
      if (t) m_low = LOW_CYC;
    end else if (m_low > 0) begin
      m_low--;
      if (m_low == 0) m_gap = GAP_CYC;
      if (t) enqueue();
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        if (t) m_low = LOW_CYC;
        else if (m_pend > 0) begin
          m_pend--;
          m_low = LOW_CYC;
        end
      end else if (t) enqueue();
    end
  endtask

  // Drive one cycle, advance the model on the edge, then check at the
  // following falling edge.
  task automatic step(input bit r, input bit t);
    rst  = r;
    trig = t;
    @(posedge clk);
    model_edge(r, t);
    cyc++;
    @(negedge clk);
    check("out", 32'(out), 32'(m_low == 0));
    check("busy", 32'(busy), 32'(m_low > 0 || m_gap > 0));
    check("pending", 32'(pending), 32'(m_pend));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // Bit c of m puts a strobe on cycle c of the pattern.
  task automatic run_mask(input logic [63:0] m, input int len);
    for (int c = 0; c < len; c++) step(1'b1, m[c]);
  endtask

  initial begin
    // Reset held for two clocks with trig asserted.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_out", 32'(out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    idle(3);

    // Single strobe: four clocks low, then three clocks of gap.
    run_mask(64'h1, 12);
    // Strobes at offsets 0, 2 and 5 give back-to-back queued pulses.
    run_mask(64'h25, 26);
    // A burst that fills the queue, then overflows it.
    run_mask(64'hF, 30);
    // A strobe on the gap-exit edge (offset 7) with an empty queue.
    run_mask(64'h81, 16);
    // A strobe on the gap-exit edge with the queue full.
    run_mask(64'h87, 30);
    // Reset in the middle of a pulse with one strobe queued.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("midreset_out", 32'(out), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_pending", 32'(pending), 32'd0);
    idle(10);

    // Random strobes with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
